read_response_tx: RTL and testbench
===================================

Name: read_response_tx

Overview:
Store-and-forward transmitter for the read-response (R) channel of the DDR controller's host interface.
- Captures one completed DDR read burst for a given RID and replays it to the host as AXI-style R beats under a valid/ready handshake.
- On acceptance of the last beat, pulses pop/popped_rid so the transaction FIFO retires that RID's entry.
- Sits between the DDR read-data return path and the host R channel.

Parameters:
DATA_WIDTH, 32, width of one read data beat
LEN_WIDTH, 3, width of burst length field (beats minus one)
BEAT_DEPTH, 8, beat buffer entries; must equal 2**LEN_WIDTH

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
cmd_valid  input  1  scheduler presents a read burst about to return
cmd_rid  input  2  RID of that burst
cmd_len  input  LEN_WIDTH  beats minus one
cmd_ready  output  1  block can accept a new burst command
dq_valid  input  1  one read data beat valid from DDR datapath
dq_data  input  DATA_WIDTH  read data beat
rvalid  output  1  R beat valid to host
rready  input  1  host accepts R beat
rdata  output  DATA_WIDTH  R beat data
rid  output  2  R beat ID
rresp  output  2  response code, always OKAY (2'b00)
rlast  output  1  final beat of burst
pop  output  1  one-cycle retire pulse to transaction FIFO
popped_rid  output  2  RID being retired, valid with pop
drop_err  output  1  one-cycle pulse: dq beat arrived outside CAPTURE

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State IDLE. Beat counters and pointers 0. Buffer contents don't-care.
- FSM states: IDLE, CAPTURE, SEND, RELEASE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_rid and cmd_len, clear write pointer, go to CAPTURE next cycle.
- CAPTURE:
  - cmd_ready=0.
  - Each cycle with dq_valid=1, write dq_data to buffer[wptr] and increment wptr.
  - When the beat written has wptr==latched len: go to SEND next cycle and clear rptr.
  - dq_valid gaps are allowed; no timeout.
- SEND:
  - rvalid=1, rdata=buffer[rptr], rid=latched rid, rlast=(rptr==len).
  - On rvalid&rready with rlast=0: increment rptr.
  - On rvalid&rready with rlast=1: go to RELEASE.
  - rdata, rid and rlast hold stable while rvalid=1 and rready=0.
- RELEASE:
  - Lasts exactly one cycle.
  - pop=1, popped_rid=latched rid, rvalid=0, then return to IDLE.
  - cmd_ready is 0 in this cycle, so the minimum spacing between commands is one idle cycle after pop.
- Latency:
  - The first beat is presented one cycle after the last dq beat is captured.
  - A single-beat burst (len=0) with rready held high:
    - cmd accepted cycle 0
    - dq captured cycle 1
    - rvalid cycle 2
    - pop cycle 3
- Width and counter rules: pointers are LEN_WIDTH bits. len = 2**LEN_WIDTH-1 fills the buffer exactly with no wrap.
- drop_err: dq_valid=1 in IDLE, SEND or RELEASE is ignored (no buffer write) and pulses drop_err for one cycle.
- Simultaneous events:
  - cmd_valid is only sampled in IDLE.
  - rready is only meaningful in SEND.
  - The pop pulse never overlaps rvalid.
- Reset mid-operation: state returns to IDLE; rvalid and pop drop immediately (asynchronous). No pop is emitted for the aborted burst.

Decomposition:
- Shared package ddr_ctrl_pkg holds:
  - RID_W=2
  - rresp encodings (OKAY, EXOKAY, SLVERR, DECERR)
  - state enum for this FSM
- One sub-module, read_beat_buffer: BEAT_DEPTH x DATA_WIDTH register array with write-enable/write-index port and combinational read-index port, reset-free.
- FSM and counters stay in read_response_tx.

Test Plan:
1. Reset, then cmd rid=2 len=0, dq 0xDEADBEEF, rready=1 -> rvalid cycle 2 with rdata=0xDEADBEEF, rid=2, rlast=1, rresp=0; pop=1 with popped_rid=2 cycle 3; cmd_ready=1 cycle 4.
2. cmd rid=1 len=3, dq beats 0x10,0x11,0x12,0x13 with a 2-cycle gap after beat 1 -> R beats 0x10..0x13 in order, rlast only on 0x13, single pop with rid=1.
3. Backpressure: len=1, rready=0 for 5 cycles then 1 -> rdata/rid/rlast stable across stall, exactly 2 handshakes, pop once.
4. Max burst: len=7, 8 beats 0xA0..0xA7 -> 8 R beats, no wrap corruption, rlast on 0xA7.
5. Stray dq_valid in IDLE and during SEND -> drop_err pulses each time, buffer and output data unaffected.
6. Assert n_rst mid-SEND (after beat 1 of 4) -> rvalid=0 immediately, no pop, cmd_ready=1 after release; a following len=0 burst completes normally.

Source files
------------

// File: rtl/ddr_ctrl_pkg.sv
// Shared DDR controller types: host ID width,
// R-channel response codes and read-response FSM states.
package ddr_ctrl_pkg;

  localparam int RID_W = 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_e;

  typedef enum logic [1:0] {
    RR_IDLE,
    RR_CAPTURE,
    RR_SEND,
    RR_RELEASE
  } rr_state_e;

endpackage

// File: rtl/read_beat_buffer.sv
// Beat storage for one read burst: registered write port,
// combinational read port, no reset on the array.
module read_beat_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/read_response_tx.sv
// Store-and-forward R-channel transmitter: captures one DDR read
// burst, replays it to the host, then pulses pop to retire the RID.
import ddr_ctrl_pkg::*;

module read_response_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 3,
  parameter int BEAT_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cmd_valid,
  input  logic [RID_W-1:0]      cmd_rid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  input  logic                  dq_valid,
  input  logic [DATA_WIDTH-1:0] dq_data,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [RID_W-1:0]      rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  pop,
  output logic [RID_W-1:0]      popped_rid,
  output logic                  drop_err
);

  rr_state_e            state_q, state_d;
  logic [RID_W-1:0]     rid_q, rid_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] wptr_q, wptr_d;
  logic [LEN_WIDTH-1:0] rptr_q, rptr_d;
  logic                 buf_we;
  logic [DATA_WIDTH-1:0] buf_rdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RR_IDLE;
      rid_q   <= '0;
      len_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      rid_q   <= rid_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rid_d   = rid_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    buf_we  = 1'b0;
    unique case (state_q)
      RR_IDLE: begin
        if (cmd_valid) begin
          rid_d   = cmd_rid;
          len_d   = cmd_len;
          wptr_d  = '0;
          state_d = RR_CAPTURE;
        end
      end
      RR_CAPTURE: begin
        if (dq_valid) begin
          buf_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == len_q) begin
            rptr_d  = '0;
            state_d = RR_SEND;
          end
        end
      end
      RR_SEND: begin
        if (rready) begin
          if (rptr_q == len_q) state_d = RR_RELEASE;
          else rptr_d = rptr_q + 1'b1;
        end
      end
      RR_RELEASE: state_d = RR_IDLE;
      default: state_d = RR_IDLE;
    endcase
  end

  read_beat_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BEAT_DEPTH),
    .IDX_W     (LEN_WIDTH)
  ) u_buf (
    .clk    (clk),
    .we_i   (buf_we),
    .widx_i (wptr_q),
    .wdata_i(dq_data),
    .ridx_i (rptr_q),
    .rdata_o(buf_rdata)
  );

  // Outputs decode straight from state so reset drops them at once.
  assign cmd_ready  = (state_q == RR_IDLE);
  assign rvalid     = (state_q == RR_SEND);
  assign pop        = (state_q == RR_RELEASE);
  assign rdata      = rvalid ? buf_rdata : '0;
  assign rid        = rvalid ? rid_q : '0;
  assign rlast      = rvalid && (rptr_q == len_q);
  assign rresp      = RESP_OKAY;
  assign popped_rid = pop ? rid_q : '0;
  assign drop_err   = dq_valid && (state_q != RR_CAPTURE);

endmodule

// File: tb/tb_read_response_tx.sv
// Randomized bench for read_response_tx against a queue-based
// model of expected R beats and retired RIDs.
module tb_read_response_tx;
  localparam int DW = 32;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_rid = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready;
  logic          dq_valid = 1'b0;
  logic [DW-1:0] dq_data = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rid;
  logic [1:0]    rresp;
  logic          rlast;
  logic          pop;
  logic [1:0]    popped_rid;
  logic          drop_err;

  read_response_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .BEAT_DEPTH(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_rid(cmd_rid), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready),
    .dq_valid(dq_valid), .dq_data(dq_data),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast),
    .pop(pop), .popped_rid(popped_rid), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  id;
    logic        last;
  } beat_t;
  typedef logic [31:0] word_q_t[$];

  beat_t      exp_q[$];
  logic [1:0] rid_exp[$];
  int n_chk = 0, n_pass = 0;
  int hs_cnt = 0, pop_cnt = 0;
  int rr_mode = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // rready: 0 = held high, 1 = random, other = held low
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: rready = 1'b1;
      1: rready = 1'($urandom_range(0, 1));
      default: rready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (n_rst && mon_en) begin
      if (rvalid) begin
        check("pop_overlaps_rvalid", {63'b0, pop}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 64'd1, 64'd0);
        end else begin
          check("rdata", {32'b0, rdata}, {32'b0, exp_q[0].d});
          check("rid", {62'b0, rid}, {62'b0, exp_q[0].id});
          check("rlast", {63'b0, rlast}, {63'b0, exp_q[0].last});
          check("rresp", {62'b0, rresp}, 64'd0);
          if (rready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      if (pop) begin
        if (rid_exp.size() == 0) begin
          check("unexpected_pop", 64'd1, 64'd0);
        end else begin
          check("popped_rid", {62'b0, popped_rid}, {62'b0, rid_exp[0]});
          void'(rid_exp.pop_front());
          check("beats_left_at_pop", 64'(exp_q.size()), 64'd0);
        end
        pop_cnt++;
      end
    end
  end

  task automatic burst(input logic [1:0] id, input int len,
                       input word_q_t d, input int maxgap,
                       input int gap_idx, input int gap_n);
    int w;
    beat_t b;
    w = 0;
    while (!cmd_ready && w < 100) begin
      step();
      w++;
    end
    check("cmd_ready_wait", {63'b0, cmd_ready}, 64'd1);
    for (int i = 0; i <= len; i++) begin
      b.d = d[i];
      b.id = id;
      b.last = (i == len);
      exp_q.push_back(b);
    end
    rid_exp.push_back(id);
    cmd_valid = 1'b1;
    cmd_rid = id;
    cmd_len = len[LW-1:0];
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, maxgap)) step();
      if (i == gap_idx + 1) repeat (gap_n) step();
      dq_valid = 1'b1;
      dq_data = d[i];
      #1;
      check("capture_no_drop", {63'b0, drop_err}, 64'd0);
      step();
      dq_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int w;
    w = 0;
    while (pop_cnt < target && w < 300) begin
      step();
      w++;
    end
    check("pop_seen", {63'b0, pop_cnt >= target}, 64'd1);
  endtask

  task automatic wait_rvalid();
    int w;
    w = 0;
    while (!rvalid && w < 100) begin
      step();
      w++;
    end
    check("rvalid_seen", {63'b0, rvalid}, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_q_t d;
    beat_t b;
    int h, p, len;

    #3;
    check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    check("rst_rvalid", {63'b0, rvalid}, 64'd0);
    check("rst_pop", {63'b0, pop}, 64'd0);
    check("rst_rlast", {63'b0, rlast}, 64'd0);
    check("rst_rdata", {32'b0, rdata}, 64'd0);
    check("rst_drop_err", {63'b0, drop_err}, 64'd0);
    #4 n_rst = 1'b1;
    step();
    mon_en = 1'b1;

    // single-beat latency
    b.d = 32'hDEADBEEF;
    b.id = 2'd2;
    b.last = 1'b1;
    exp_q.push_back(b);
    rid_exp.push_back(2'd2);
    cmd_valid = 1'b1;
    cmd_rid = 2'd2;
    cmd_len = '0;
    check("t1_cmd_ready_c0", {63'b0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
    dq_valid = 1'b1;
    dq_data = 32'hDEADBEEF;
    check("t1_cmd_ready_c1", {63'b0, cmd_ready}, 64'd0);
    check("t1_rvalid_c1", {63'b0, rvalid}, 64'd0);
    step();
    dq_valid = 1'b0;
    check("t1_rvalid_c2", {63'b0, rvalid}, 64'd1);
    check("t1_rdata_c2", {32'b0, rdata}, 64'hDEADBEEF);
    check("t1_rlast_c2", {63'b0, rlast}, 64'd1);
    step();
    check("t1_pop_c3", {63'b0, pop}, 64'd1);
    check("t1_popped_rid_c3", {62'b0, popped_rid}, 64'd2);
    check("t1_rvalid_c3", {63'b0, rvalid}, 64'd0);
    check("t1_cmd_ready_c3", {63'b0, cmd_ready}, 64'd0);
    step();
    check("t1_pop_c4", {63'b0, pop}, 64'd0);
    check("t1_cmd_ready_c4", {63'b0, cmd_ready}, 64'd1);

    // four beats with a gap after beat 1
    h = hs_cnt;
    p = pop_cnt;
    d = '{32'h10, 32'h11, 32'h12, 32'h13};
    burst(2'd1, 3, d, 0, 1, 2);
    wait_done(p + 1);
    repeat (3) step();
    check("t2_handshakes", 64'(hs_cnt - h), 64'd4);
    check("t2_pops", 64'(pop_cnt - p), 64'd1);

    // backpressure
    rr_mode = 2;
    h = hs_cnt;
    p = pop_cnt;
    d = '{32'h55, 32'h66};
    burst(2'd0, 1, d, 1, -5, 0);
    wait_rvalid();
    repeat (5) begin
      check("t3_stall_rvalid", {63'b0, rvalid}, 64'd1);
      check("t3_stall_rdata", {32'b0, rdata}, 64'h55);
      check("t3_stall_rid", {62'b0, rid}, 64'd0);
      check("t3_stall_rlast", {63'b0, rlast}, 64'd0);
      step();
    end
    rr_mode = 0;
    wait_done(p + 1);
    repeat (3) step();
    check("t3_handshakes", 64'(hs_cnt - h), 64'd2);
    check("t3_pops", 64'(pop_cnt - p), 64'd1);

    // maximum burst fills buffer exactly
    h = hs_cnt;
    p = pop_cnt;
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3,
          32'hA4, 32'hA5, 32'hA6, 32'hA7};
    burst(2'd3, 7, d, 1, -5, 0);
    wait_done(p + 1);
    check("t4_handshakes", 64'(hs_cnt - h), 64'd8);

    // stray dq beats in IDLE and SEND
    step();
    check("t5_idle", {63'b0, cmd_ready}, 64'd1);
    dq_valid = 1'b1;
    dq_data = 32'hBAD0;
    #1;
    check("t5_drop_idle", {63'b0, drop_err}, 64'd1);
    step();
    dq_valid = 1'b0;
    #1;
    check("t5_drop_clear", {63'b0, drop_err}, 64'd0);
    rr_mode = 2;
    p = pop_cnt;
    d = '{32'h77, 32'h88};
    burst(2'd3, 1, d, 0, -5, 0);
    wait_rvalid();
    dq_valid = 1'b1;
    dq_data = 32'hBAD1;
    #1;
    check("t5_drop_send", {63'b0, drop_err}, 64'd1);
    check("t5_send_rdata", {32'b0, rdata}, 64'h77);
    step();
    dq_valid = 1'b0;
    rr_mode = 0;
    wait_done(p + 1);

    // reset in the middle of SEND
    rr_mode = 2;
    d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    burst(2'd2, 3, d, 0, -5, 0);
    wait_rvalid();
    rr_mode = 0;
    step();
    rr_mode = 2;
    step();
    check("t6_rvalid_before_rst", {63'b0, rvalid}, 64'd1);
    check("t6_rdata_beat1", {32'b0, rdata}, 64'hC1);
    p = pop_cnt;
    n_rst = 1'b0;
    #1;
    check("t6_rvalid_async", {63'b0, rvalid}, 64'd0);
    check("t6_pop_async", {63'b0, pop}, 64'd0);
    exp_q.delete();
    rid_exp.delete();
    step();
    step();
    n_rst = 1'b1;
    #1;
    check("t6_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    repeat (3) step();
    check("t6_no_pop", 64'(pop_cnt - p), 64'd0);
    rr_mode = 0;
    d = '{32'h1234};
    burst(2'd1, 0, d, 0, -5, 0);
    wait_done(p + 1);

    // random bursts with random backpressure
    rr_mode = 1;
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(0, 7);
      d.delete();
      for (int i = 0; i <= len; i++) d.push_back($urandom);
      h = hs_cnt;
      p = pop_cnt;
      burst(2'($urandom_range(0, 3)), len, d, 2, -5, 0);
      wait_done(p + 1);
      check("rand_handshakes", 64'(hs_cnt - h), 64'(len + 1));
    end
    rr_mode = 0;
    repeat (3) step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
